// File: rtl/mio_bus_responder.sv
// mio_bus_responder: memory/IO bus responder with a word RAM, LED and switch ports and a compare timer.
// Optional macro MIO_EXT_INT_EN adds a synchronized, edge-detected external interrupt input (ext_irq).
module mio_bus_responder #(
    parameter int          RAM_AW      = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CPU_MIO,
    input  logic        MemRW,
    input  logic [31:0] Addr_out,
    input  logic [31:0] Data_out,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
    output logic        INT,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
`ifdef MIO_EXT_INT_EN
    input  logic        ext_irq,
`endif
    output logic        bus_err
);

    localparam int          RAM_WORDS = 1 << RAM_AW;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [31:0] ADDR_LED  = 32'hE000_0000;
    localparam logic [31:0] ADDR_SW   = 32'hF000_0000;
    localparam logic [31:0] ADDR_CMP  = 32'hF000_0004;
    localparam logic [31:0] ADDR_CNT  = 32'hF000_0008;
    localparam logic [31:0] ADDR_STAT = 32'hF000_000C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [3:0]         wait_cnt_r;
    logic [31:0]        addr_r;
    logic [31:0]        wdata_r;
    logic               we_r;

    logic [31:0]        ram_r [RAM_WORDS];

    logic [31:0]        cmp_r;
    logic [31:0]        cnt_r;
    logic               pending_r;
    logic               int_en_r;

    logic [31:0]        dec_addr_s;
    logic               dec_we_s;
    logic [31:0]        word_addr_s;
    logic [RAM_AW-1:0]  ram_idx_s;
    logic               sel_ram_s;
    logic               sel_led_s;
    logic               sel_sw_s;
    logic               sel_cmp_s;
    logic               sel_cnt_s;
    logic               sel_stat_s;
    logic               unmapped_s;
    logic [31:0]        status_s;
    logic [31:0]        rdata_s;
    logic [31:0]        resp_s;
    logic               commit_s;
    logic               match_s;
    logic               irq_src_s;

`ifdef MIO_EXT_INT_EN
    logic [1:0]         ext_sync_r;
    logic               ext_prev_r;
    logic               ext_pending_r;
    logic               ext_edge_s;

    assign ext_edge_s = ext_sync_r[1] & ~ext_prev_r;
`endif

    // Address decode and read mux; in IDLE the live bus is decoded so zero-wait accesses complete in time.
    always_comb begin
        dec_addr_s = addr_r;
        dec_we_s   = we_r;
        if (state_r == ST_IDLE) begin
            dec_addr_s = Addr_out;
            dec_we_s   = MemRW;
        end else begin
            dec_addr_s = addr_r;
            dec_we_s   = we_r;
        end
        word_addr_s = dec_addr_s & 32'hFFFF_FFFC;
        ram_idx_s   = word_addr_s[RAM_AW+1:2];
        sel_ram_s   = (word_addr_s >> (RAM_AW + 2)) == 32'd0;
        sel_led_s   = (word_addr_s == ADDR_LED);
        sel_sw_s    = (word_addr_s == ADDR_SW);
        sel_cmp_s   = (word_addr_s == ADDR_CMP);
        sel_cnt_s   = (word_addr_s == ADDR_CNT);
        sel_stat_s  = (word_addr_s == ADDR_STAT);
        unmapped_s  = !(sel_ram_s | sel_led_s | sel_sw_s | sel_cmp_s | sel_cnt_s | sel_stat_s);
`ifdef MIO_EXT_INT_EN
        status_s    = {29'd0, ext_pending_r, int_en_r, pending_r};
        irq_src_s   = pending_r | ext_pending_r;
`else
        status_s    = {30'd0, int_en_r, pending_r};
        irq_src_s   = pending_r;
`endif
        rdata_s = ERR_DATA;
        if (sel_ram_s) begin
            rdata_s = ram_r[ram_idx_s];
        end else if (sel_led_s) begin
            rdata_s = {16'd0, led_out};
        end else if (sel_sw_s) begin
            rdata_s = {16'd0, sw_in};
        end else if (sel_cmp_s) begin
            rdata_s = cmp_r;
        end else if (sel_cnt_s) begin
            rdata_s = cnt_r;
        end else if (sel_stat_s) begin
            rdata_s = status_s;
        end else begin
            rdata_s = ERR_DATA;
        end
        resp_s   = dec_we_s ? 32'd0 : rdata_s;
        commit_s = (state_r == ST_DONE) && we_r;
        match_s  = (cmp_r != 32'd0) && (cnt_r == cmp_r);
    end

    // Request sequencing: accept, count wait states, then a one-cycle completion with registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            we_r       <= 1'b0;
            MIO_ready  <= 1'b0;
            Data_in    <= 32'd0;
            bus_err    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    MIO_ready <= 1'b0;
                    Data_in   <= 32'd0;
                    if (CPU_MIO) begin
                        addr_r     <= Addr_out;
                        wdata_r    <= Data_out;
                        we_r       <= MemRW;
                        wait_cnt_r <= WAIT_INIT;
                        if (WAIT_CYCLES == 0) begin
                            state_r   <= ST_DONE;
                            MIO_ready <= 1'b1;
                            Data_in   <= resp_s;
                            if (unmapped_s) begin
                                bus_err <= 1'b1;
                            end
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r <= 4'd1) begin
                        state_r   <= ST_DONE;
                        MIO_ready <= 1'b1;
                        Data_in   <= resp_s;
                        if (unmapped_s) begin
                            bus_err <= 1'b1;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    MIO_ready <= 1'b0;
                    Data_in   <= 32'd0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    MIO_ready <= 1'b0;
                    Data_in   <= 32'd0;
                end
            endcase
        end
    end

    // Word RAM: no reset; writes commit at the edge that closes the completion cycle.
    always_ff @(posedge clk) begin
        if (!rst && commit_s && sel_ram_s) begin
            ram_r[ram_idx_s] <= wdata_r;
        end
    end

    // LED register.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_out <= 16'd0;
        end else if (commit_s && sel_led_s) begin
            led_out <= wdata_r[15:0];
        end
    end

    // Compare timer, pending flag and interrupt enable; a timer match beats a software clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_r     <= 32'd0;
            cnt_r     <= 32'd0;
            pending_r <= 1'b0;
            int_en_r  <= 1'b0;
            INT       <= 1'b0;
        end else begin
            if (commit_s && sel_cmp_s) begin
                cmp_r <= wdata_r;
                cnt_r <= 32'd0;
            end else if ((cmp_r == 32'd0) || match_s) begin
                cnt_r <= 32'd0;
            end else begin
                cnt_r <= cnt_r + 32'd1;
            end
            if (match_s) begin
                pending_r <= 1'b1;
            end else if (commit_s && sel_stat_s && wdata_r[0]) begin
                pending_r <= 1'b0;
            end
            if (commit_s && sel_stat_s) begin
                int_en_r <= wdata_r[1];
            end
            INT <= irq_src_s & int_en_r;
        end
    end

`ifdef MIO_EXT_INT_EN
    // External interrupt: two-flop synchronizer, rising-edge detect, sticky pending with set priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_sync_r    <= 2'b00;
            ext_prev_r    <= 1'b0;
            ext_pending_r <= 1'b0;
        end else begin
            ext_sync_r <= {ext_sync_r[0], ext_irq};
            ext_prev_r <= ext_sync_r[1];
            if (ext_edge_s) begin
                ext_pending_r <= 1'b1;
            end else if (commit_s && sel_stat_s && wdata_r[2]) begin
                ext_pending_r <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mio_bus_responder.sv
// Bench for mio_bus_responder: transaction-level model checked every cycle, plus directed literal pins.
module tb_mio_bus_responder;
    localparam int          AW        = 10;
    localparam int          W         = 1;
    localparam logic [31:0] RAM_BYTES = 32'h0000_1000;
    localparam logic [31:0] A_LED     = 32'hE000_0000;
    localparam logic [31:0] A_SW      = 32'hF000_0000;
    localparam logic [31:0] A_CMP     = 32'hF000_0004;
    localparam logic [31:0] A_CNT     = 32'hF000_0008;
    localparam logic [31:0] A_STAT    = 32'hF000_000C;
    localparam logic [31:0] ERR       = 32'hDEADBEEF;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cpu_mio, mem_rw;
    logic [31:0] addr, wdata;
    logic [15:0] sw;
    logic        ext;
    logic [31:0] data_in;
    logic        ready, irq, berr;
    logic [15:0] led;

    logic        rst3, cpu3, we3;
    logic [31:0] addr3, wd3;
    logic [31:0] data3;
    logic        ready3, irq3, berr3;
    logic [15:0] led3;

    int n_checks = 0;
    int n_fail   = 0;

    mio_bus_responder #(.RAM_AW(AW), .WAIT_CYCLES(W), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst), .CPU_MIO(cpu_mio), .MemRW(mem_rw), .Addr_out(addr),
        .Data_out(wdata), .Data_in(data_in), .MIO_ready(ready), .INT(irq),
        .sw_in(sw), .led_out(led),
`ifdef MIO_EXT_INT_EN
        .ext_irq(ext),
`endif
        .bus_err(berr)
    );

    mio_bus_responder #(.RAM_AW(AW), .WAIT_CYCLES(3), .ERR_DATA(ERR)) dut3 (
        .clk(clk), .rst(rst3), .CPU_MIO(cpu3), .MemRW(we3), .Addr_out(addr3),
        .Data_out(wd3), .Data_in(data3), .MIO_ready(ready3), .INT(irq3),
        .sw_in(16'h0000), .led_out(led3),
`ifdef MIO_EXT_INT_EN
        .ext_irq(ext),
`endif
        .bus_err(berr3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid = 1'b0;
    int          m_left  = 0;       // cycles until the access finishes; 1 = completion cycle
    logic [31:0] m_addr, m_wd, m_dexp;
    logic        m_we, m_dknown;
    logic [31:0] m_cmp, m_cnt;
    logic        m_pend, m_inten, m_int, m_berr;
    logic [15:0] m_led;
    logic [31:0] m_ram [int];

    function automatic void resolve();
        logic [31:0] a, rd;
        a = {m_addr[31:2], 2'b00};
        m_dknown = 1'b1;
        if (a < RAM_BYTES) begin
            if (m_ram.exists(int'(a >> 2))) rd = m_ram[int'(a >> 2)];
            else begin rd = 32'd0; m_dknown = 1'b0; end
        end
        else if (a == A_LED)  rd = {16'd0, m_led};
        else if (a == A_SW)   rd = {16'd0, sw};
        else if (a == A_CMP)  rd = m_cmp;
        else if (a == A_CNT)  rd = m_cnt;
        else if (a == A_STAT) rd = {30'd0, m_inten, m_pend};
        else begin rd = ERR; m_berr = 1'b1; end
        m_dexp = m_we ? 32'd0 : rd;
        if (m_we) m_dknown = 1'b1;
    endfunction

    always @(posedge clk) begin : model_step
        logic        n_int, match, commit;
        logic [31:0] c_addr, c_wd;
        if (rst) begin
            m_valid = 1'b1; m_left = 0; m_cmp = 32'd0; m_cnt = 32'd0; m_pend = 1'b0;
            m_inten = 1'b0; m_int = 1'b0; m_led = 16'd0; m_berr = 1'b0;
            m_dexp = 32'd0; m_dknown = 1'b1; m_we = 1'b0; m_addr = 32'd0; m_wd = 32'd0;
        end else begin
            n_int  = m_pend & m_inten;
            match  = (m_cmp != 32'd0) && (m_cnt == m_cmp);
            commit = (m_left == 1) && m_we;
            c_addr = {m_addr[31:2], 2'b00};
            c_wd   = m_wd;
            if (m_left == 0) begin
                if (cpu_mio) begin
                    m_addr = addr; m_wd = wdata; m_we = mem_rw; m_left = W + 1;
                    if (m_left == 1) resolve();
                end
            end else begin
                m_left--;
                if (m_left == 1) resolve();
            end
            if (commit && c_addr == A_CMP) begin m_cmp = c_wd; m_cnt = 32'd0; end
            else if (m_cmp == 32'd0 || match) m_cnt = 32'd0;
            else m_cnt = m_cnt + 32'd1;
            if (match) m_pend = 1'b1;
            else if (commit && c_addr == A_STAT && c_wd[0]) m_pend = 1'b0;
            if (commit && c_addr == A_STAT) m_inten = c_wd[1];
            if (commit && c_addr == A_LED) m_led = c_wd[15:0];
            if (commit && c_addr < RAM_BYTES) m_ram[int'(c_addr >> 2)] = c_wd;
            m_int = n_int;
        end
    end

    // Per-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("ready", {31'd0, ready}, {31'd0, (m_left == 1)});
            if (!(m_left == 1 && !m_dknown))
                check("data_in", data_in, (m_left == 1) ? m_dexp : 32'd0);
            check("int", {31'd0, irq}, {31'd0, m_int});
            check("led_out", {16'd0, led}, {16'd0, m_led});
            check("bus_err", {31'd0, berr}, {31'd0, m_berr});
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
        int lat;
        cpu_mio = 1'b1; mem_rw = we; addr = a; wdata = d; lat = 0;
        do begin @(negedge clk); lat++; end while (!ready && lat < 40);
        check("latency", lat, W + 1);
        rd = data_in;
        cpu_mio = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus3(input logic we, input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
        int lat;
        cpu3 = 1'b1; we3 = we; addr3 = a; wd3 = d; lat = 0;
        do begin @(negedge clk); lat++; end while (!ready3 && lat < 40);
        check("latency3", lat, 4);
        rd = data3;
        cpu3 = 1'b0;
        @(negedge clk);
    endtask

    task automatic align_cnt(input logic [31:0] v);
        for (int k = 0; k < 20 && m_cnt != v; k++) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] rd;
        int k;
        rst = 1'b1; cpu_mio = 1'b0; mem_rw = 1'b0; addr = 32'd0; wdata = 32'd0; sw = 16'd0; ext = 1'b0;
        rst3 = 1'b1; cpu3 = 1'b0; we3 = 1'b0; addr3 = 32'd0; wd3 = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0; rst3 = 1'b0;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_data", data_in, 32'd0);
        check("rst_int", {31'd0, irq}, 32'd0);
        check("rst_led", {16'd0, led}, 32'd0);
        check("rst_berr", {31'd0, berr}, 32'd0);

        bus(1'b0, A_LED, 32'd0, rd);              check("rd_led0", rd, 32'h0000_0000);
        bus(1'b1, 32'h0000_0010, 32'h12345678, rd);
        bus(1'b0, 32'h0000_0010, 32'd0, rd);      check("rd_ram10", rd, 32'h12345678);
        check("led_still0", {16'd0, led}, 32'd0);
        bus(1'b1, A_LED, 32'h0000_ABCD, rd);      check("led_abcd", {16'd0, led}, 32'h0000_ABCD);
        bus(1'b0, A_LED, 32'd0, rd);              check("rd_led", rd, 32'h0000_ABCD);
        sw = 16'h00F0;
        bus(1'b0, A_SW, 32'd0, rd);               check("rd_sw", rd, 32'h0000_00F0);
        bus(1'b1, A_SW, 32'hFFFF_FFFF, rd);
        sw = 16'h1234;
        bus(1'b0, A_SW, 32'd0, rd);               check("rd_sw2", rd, 32'h0000_1234);

        bus(1'b1, 32'h0000_0FFC, 32'hCAFEF00D, rd);
        bus(1'b0, 32'h0000_0FFF, 32'd0, rd);      check("rd_ramtop", rd, 32'hCAFEF00D);
        bus(1'b0, 32'h0000_0013, 32'd0, rd);      check("rd_lowbits", rd, 32'h12345678);
        check("berr_still0", {31'd0, berr}, 32'd0);

        bus(1'b1, A_CMP, 32'd5, rd);
        bus(1'b0, A_CMP, 32'd0, rd);              check("rd_cmp", rd, 32'd5);
        bus(1'b1, A_STAT, 32'h2, rd);
        for (k = 0; k < 20 && !irq; k++) @(negedge clk);
        check("int_rise", {31'd0, irq}, 32'd1);
        align_cnt(32'd3);
        bus(1'b1, A_STAT, 32'h3, rd);             // clear lands on a timer match
        bus(1'b0, A_STAT, 32'd0, rd);             check("stat_tie", rd, 32'h3);
        check("int_held", {31'd0, irq}, 32'd1);
        align_cnt(32'd0);
        bus(1'b1, A_STAT, 32'h3, rd);             // clear away from a match
        bus(1'b0, A_STAT, 32'd0, rd);             check("stat_clr", rd, 32'h2);
        check("int_fall", {31'd0, irq}, 32'd0);
        bus(1'b1, A_STAT, 32'h0, rd);
        bus(1'b1, A_CMP, 32'd0, rd);
        repeat (3) @(negedge clk);
        bus(1'b0, A_CNT, 32'd0, rd);              check("cnt_stopped", rd, 32'd0);

        bus(1'b0, 32'h8000_0000, 32'd0, rd);      check("rd_unmapped", rd, 32'hDEADBEEF);
        check("berr_set", {31'd0, berr}, 32'd1);
        bus(1'b0, 32'h0000_0010, 32'd0, rd);      check("rd_after_err", rd, 32'h12345678);
        check("berr_sticky", {31'd0, berr}, 32'd1);
        bus(1'b0, 32'h0000_1000, 32'd0, rd);      check("rd_past_ram", rd, 32'hDEADBEEF);
        bus(1'b0, 32'hF000_0010, 32'd0, rd);      check("rd_hole", rd, 32'hDEADBEEF);

        // Reset during wait states on the three-wait-state instance.
        bus3(1'b1, 32'h0000_0020, 32'hAAAA_5555, rd);
        cpu3 = 1'b1; we3 = 1'b1; addr3 = 32'h0000_0020; wd3 = 32'h1111_2222;
        repeat (2) @(negedge clk);
        check("w3_inwait", {31'd0, ready3}, 32'd0);
        rst3 = 1'b1; cpu3 = 1'b0;
        @(negedge clk);
        rst3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("abort_ready", {31'd0, ready3}, 32'd0);
            @(negedge clk);
        end
        bus3(1'b0, 32'h0000_0020, 32'd0, rd);     check("rd_after_abort", rd, 32'hAAAA_5555);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
